// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_pkg
// Desc     : RV32M func3 codes, FSM encodings and operand-sign helpers.
// Revision : 1.0
// ============================================================================
package muldiv_seq_pkg;

    localparam logic [2:0] MUL_OP_MUL    = 3'b000;
    localparam logic [2:0] MUL_OP_MULH   = 3'b001;
    localparam logic [2:0] MUL_OP_MULHSU = 3'b010;
    localparam logic [2:0] MUL_OP_MULHU  = 3'b011;
    localparam logic [2:0] MUL_OP_DIV    = 3'b100;
    localparam logic [2:0] MUL_OP_DIVU   = 3'b101;
    localparam logic [2:0] MUL_OP_REM    = 3'b110;
    localparam logic [2:0] MUL_OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    function automatic logic op1_signed(input logic [2:0] f);
        return (f == MUL_OP_MULH) || (f == MUL_OP_MULHSU) ||
               (f == MUL_OP_DIV)  || (f == MUL_OP_REM);
    endfunction

    function automatic logic op2_signed(input logic [2:0] f);
        return (f == MUL_OP_MULH) || (f == MUL_OP_DIV) || (f == MUL_OP_REM);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Desc     : One shift-add multiply or restoring-divide iteration on {hi,lo}.
// Revision : 1.0
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] operand,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN+1:0] w_a;
    logic [XLEN+1:0] w_b;
    logic [XLEN+1:0] w_sum;
    logic            w_neg;

    // A single adder serves both: divide subtracts via invert-and-carry-in.
    always_comb begin
        w_a    = is_div ? {1'b0, hi_in, lo_in[XLEN-1]} : {2'b00, hi_in};
        w_b    = (is_div || lo_in[0]) ? {2'b00, operand} : '0;
        w_sum  = w_a + (w_b ^ {(XLEN+2){is_div}}) + {{(XLEN+1){1'b0}}, is_div};
        w_neg  = w_sum[XLEN+1];
        hi_out = w_sum[XLEN:1];
        lo_out = {w_sum[0], lo_in[XLEN-1:1]};
        if (is_div) begin
            hi_out = w_neg ? w_a[XLEN-1:0] : w_sum[XLEN-1:0];
            lo_out = {lo_in[XLEN-2:0], ~w_neg};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Desc     : Iterative RV32M multiply/divide unit, STEP bits per cycle.
// Revision : 1.0
// ============================================================================
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int STEP = 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            op_valid,
    input  logic            op_stall,
    input  logic            op_kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    output logic            op_ready,
    output logic [XLEN-1:0] op_out,
    output logic            op_busy
);

    localparam int              c_ITERS = XLEN / STEP;
    localparam int              c_CW    = $clog2(c_ITERS + 1);
    localparam logic [c_CW-1:0] c_LAST  = c_CW'(c_ITERS - 1);

    state_t            r_state;
    logic [c_CW-1:0]   r_cnt;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic [XLEN-1:0]   r_opnd;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_out;
    logic              r_ready;
    logic              r_busy;

    logic              w_is_div;
    logic              w_n1;
    logic              w_n2;
    logic [XLEN-1:0]   w_mag1;
    logic [XLEN-1:0]   w_mag2;
    logic              w_neg_res;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_bypass;

    assign w_is_div  = op[2];
    assign w_n1      = op1_signed(op) & op1[XLEN-1];
    assign w_n2      = op2_signed(op) & op2[XLEN-1];
    assign w_mag1    = w_n1 ? -op1 : op1;
    assign w_mag2    = w_n2 ? -op2 : op2;
    // Remainder takes the dividend's sign; products and quotients the xor.
    assign w_neg_res = (op == MUL_OP_REM) ? w_n1 : (w_n1 ^ w_n2);
    assign w_div0    = w_is_div && (op2 == '0);
    assign w_ovf     = ((op == MUL_OP_DIV) || (op == MUL_OP_REM)) &&
                       (op1 == {1'b1, {(XLEN-1){1'b0}}}) && (op2 == '1);
    assign w_bypass  = w_div0 ? (op[1] ? op1 : '1) : (op[1] ? '0 : op1);

    logic [STEP:0][XLEN-1:0] w_hi_c;
    logic [STEP:0][XLEN-1:0] w_lo_c;

    assign w_hi_c[0] = r_hi;
    assign w_lo_c[0] = r_lo;

    for (genvar i = 0; i < STEP; i++) begin : g_step
        muldiv_step #(
            .XLEN    (XLEN)
        ) u_step (
            .is_div  (r_op[2]),
            .operand (r_opnd),
            .hi_in   (w_hi_c[i]),
            .lo_in   (w_lo_c[i]),
            .hi_out  (w_hi_c[i+1]),
            .lo_out  (w_lo_c[i+1])
        );
    end

    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;
    logic [XLEN-1:0]   w_result;

    assign w_prod   = {w_hi_c[STEP], w_lo_c[STEP]};
    assign w_prod_s = r_neg ? -w_prod : w_prod;
    assign w_quo    = r_neg ? -w_lo_c[STEP] : w_lo_c[STEP];
    assign w_rem    = r_neg ? -w_hi_c[STEP] : w_hi_c[STEP];

    always_comb begin
        w_result = w_rem;
        case (r_op)
            MUL_OP_MUL:                             w_result = w_prod_s[XLEN-1:0];
            MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: w_result = w_prod_s[2*XLEN-1:XLEN];
            MUL_OP_DIV, MUL_OP_DIVU:                w_result = w_quo;
            default:                                w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_opnd  <= '0;
            r_op    <= MUL_OP_MUL;
            r_neg   <= 1'b0;
            r_out   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else if (op_kill) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op_valid && !op_stall) begin
                        r_op   <= op;
                        r_neg  <= w_neg_res;
                        r_cnt  <= '0;
                        r_hi   <= '0;
                        r_lo   <= w_is_div ? w_mag1 : w_mag2;
                        r_opnd <= w_is_div ? w_mag2 : w_mag1;
                        if (w_div0 || w_ovf) begin
                            r_state <= ST_DONE;
                            r_out   <= w_bypass;
                            r_ready <= 1'b1;
                        end else begin
                            r_state <= ST_CALC;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    r_hi  <= w_hi_c[STEP];
                    r_lo  <= w_lo_c[STEP];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_state <= ST_DONE;
                        r_out   <= w_result;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (!op_stall) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign op_ready = r_ready;
    assign op_out   = r_out;
    assign op_busy  = r_busy;

endmodule
`default_nettype wire
